uart_burst_bridge: RTL and testbench
====================================

UART_BURST_BRIDGE -- requirements
Module: uart_burst_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus and UART data word width.
REQ-002 SHALL have parameter ADDR_W, default 28, bus address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write-data FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter ID, default 4'hB, transaction ID accepted on read data.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake from uart_unit.
REQ-008 cmd_wr  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  in  ADDR_W  burst start address.
REQ-010 cmd_len  in  4  burst beats minus one (1..16 beats).
REQ-011 wd_data / wd_valid / wd_ready  in / in / out  DATA_W / 1 / 1  write-data stream from uart_ctrl.
REQ-012 rd_data / rd_valid  out / out  DATA_W / 1  read-data stream to uart_ctrl; no backpressure.
REQ-013 aw_addr / aw_len / aw_valid / aw_ready  out / out / out / in  ADDR_W / 4 / 1 / 1  write address channel.
REQ-014 w_data / w_strb / w_last / w_valid / w_ready  out / out / out / out / in  DATA_W / DATA_W/8 / 1 / 1 / 1  write data channel.
REQ-015 b_valid / b_resp / b_ready  in / in / out  1 / 2 / 1  write response channel.
REQ-016 ar_addr / ar_len / ar_valid / ar_ready  out / out / out / in  ADDR_W / 4 / 1 / 1  read address channel.
REQ-017 r_data / r_id / r_last / r_valid / r_ready  in / in / in / in / out  DATA_W / 4 / 1 / 1 / 1  read data channel.
REQ-018 err  out  1  sticky error flag.

Function
REQ-019 SHALL implement FSM states IDLE, AW, W, B, AR, R; cmd_ready = 1 only in IDLE.
REQ-020 IDLE: on cmd_valid&&cmd_ready latch cmd_addr, cmd_len, cmd_wr; next state AW if cmd_wr else AR.
REQ-021 AW/AR: aw_valid/ar_valid = 1, addr/len from latched values, held stable until ready; on valid&&ready -> W (from AW) or R (from AR); aw_valid/ar_valid low in all other states.
REQ-022 Write FIFO: push on wd_valid&&wd_ready in any state; wd_ready = !full; no bypass, so pushed data is visible on w_data the cycle after the push at earliest.
REQ-023 W: w_valid = FIFO non-empty; w_data = FIFO head; w_strb = all ones; w_last = 1 when beat count == latched len; pop and increment count on w_valid&&w_ready.
REQ-024 Pop of the final beat SHALL move to B; a push and pop in the same cycle SHALL both take effect.
REQ-025 B: b_ready = 1; on b_valid set err if b_resp != 0; then -> IDLE.
REQ-026 R: r_ready = 1; a beat with r_valid && r_id == ID registers r_data to rd_data, rd_valid pulses 1 cycle later, and count increments.
REQ-027 R: beats with r_id != ID SHALL be accepted and discarded (no rd_valid, no count change).
REQ-028 R: a matching r_last -> IDLE; r_last with count != len, or count == len without r_last, SHALL set err.
REQ-029 err SHALL be sticky, cleared only by reset; it SHALL NOT block further commands.
REQ-030 Beat counter is 4 bits and SHALL be cleared at command acceptance.

Reset
REQ-031 On rst_n low, all of the following SHALL be 0 immediately, including mid-burst: state = IDLE, FIFO empty, all valid/ready/last outputs, rd_data, err, counters, address/len registers. cmd_ready and wd_ready SHALL be 1 the first cycle after release.

Verification
REQ-032 Push 0xDEADBEEF; cmd write, addr 0x0000100, len 0 -> aw_addr 0x100, aw_len 0; w_data 0xDEADBEEF with w_last=1 and w_strb=0xF; b_resp=0 -> IDLE, err=0.
REQ-033 Write len 3 with w_ready toggling every cycle -> 4 beats in push order; w_last only on the 4th.
REQ-034 Read len 1, with beats ID, 0x3, ID (last) -> two rd_valid pulses with the ID-tagged data; the 0x3 beat is dropped.
REQ-035 Write burst ends with b_resp=2'b10 -> err=1, which stays 1 through a following successful read.
REQ-036 FIFO_DEPTH pushes with no command -> wd_ready=0 after the last push; a subsequent write burst of len FIFO_DEPTH-1 drains the FIFO and wd_ready returns to 1.
REQ-037 Assert rst_n low during W after 2 of 4 beats -> all outputs 0 asynchronously; after release cmd_ready=1 and FIFO empty.

Source files
------------

// File: rtl/uart_burst_bridge_if.sv
// Signal bundle between the UART side and the burst bus for uart_burst_bridge.
// The master modport is the bridge's view; slave is the environment's view.
interface uart_burst_bridge_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 28
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_wr;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [3:0]          cmd_len;
   logic [DATA_W-1:0]   wd_data;
   logic                wd_valid;
   logic                wd_ready;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid;
   logic [ADDR_W-1:0]   aw_addr;
   logic [3:0]          aw_len;
   logic                aw_valid;
   logic                aw_ready;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                w_last;
   logic                w_valid;
   logic                w_ready;
   logic                b_valid;
   logic [1:0]          b_resp;
   logic                b_ready;
   logic [ADDR_W-1:0]   ar_addr;
   logic [3:0]          ar_len;
   logic                ar_valid;
   logic                ar_ready;
   logic [DATA_W-1:0]   r_data;
   logic [3:0]          r_id;
   logic                r_last;
   logic                r_valid;
   logic                r_ready;
   logic                err;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
      output cmd_ready,
      input  wd_data, wd_valid,
      output wd_ready,
      output rd_data, rd_valid,
      output aw_addr, aw_len, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_valid,
      input  w_ready,
      input  b_valid, b_resp,
      output b_ready,
      output ar_addr, ar_len, ar_valid,
      input  ar_ready,
      input  r_data, r_id, r_last, r_valid,
      output r_ready,
      output err
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_len,
      input  cmd_ready,
      output wd_data, wd_valid,
      input  wd_ready,
      input  rd_data, rd_valid,
      input  aw_addr, aw_len, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_valid,
      output w_ready,
      output b_valid, b_resp,
      input  b_ready,
      input  ar_addr, ar_len, ar_valid,
      output ar_ready,
      output r_data, r_id, r_last, r_valid,
      input  r_ready,
      input  err
   );
endinterface

// File: rtl/uart_burst_bridge.sv
// Bridges UART command/data streams onto a burst bus with a write-data FIFO.
// Read beats with a foreign ID are drained silently.
module uart_burst_bridge #(
   parameter int         DATA_W     = 32,
   parameter int         ADDR_W     = 28,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [3:0] ID         = 4'hB
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_burst_bridge_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = DATA_W / 8;

   typedef logic [PW:0] ptr_t;
   localparam ptr_t P_ONE = ptr_t'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_W, S_B, S_AR, S_R
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]          len_q, len_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                run_q, run_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   ptr_t                wptr_q, wptr_d;
   ptr_t                rptr_q, rptr_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];

   logic empty, full, push, pop;
   logic in_w, last_beat, rd_hit;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                  (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

   // run_q keeps the ready outputs low while reset is held
   assign bus.cmd_ready = run_q && (state_q == S_IDLE);
   assign bus.wd_ready  = run_q && !full;

   assign in_w      = (state_q == S_W);
   assign last_beat = (cnt_q == len_q);

   assign bus.aw_valid = (state_q == S_AW);
   assign bus.aw_addr  = addr_q;
   assign bus.aw_len   = len_q;
   assign bus.ar_valid = (state_q == S_AR);
   assign bus.ar_addr  = addr_q;
   assign bus.ar_len   = len_q;

   assign bus.w_valid = in_w && !empty;
   assign bus.w_data  = mem_q[rptr_q[PW-1:0]];
   assign bus.w_strb  = {SW{in_w}};
   assign bus.w_last  = in_w && last_beat;

   assign bus.b_ready  = (state_q == S_B);
   assign bus.r_ready  = (state_q == S_R);
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.err      = err_q;

   assign push   = bus.wd_valid && bus.wd_ready;
   assign pop    = bus.w_valid && bus.w_ready;
   assign rd_hit = bus.r_valid && (bus.r_id == ID);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      run_d      = 1'b1;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      mem_d      = mem_q;

      if (push) begin
         mem_d[wptr_q[PW-1:0]] = bus.wd_data;
         wptr_d = wptr_q + P_ONE;
      end
      if (pop) begin
         rptr_d = rptr_q + P_ONE;
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && bus.cmd_ready) begin
               addr_d  = bus.cmd_addr;
               len_d   = bus.cmd_len;
               cnt_d   = 4'd0;
               state_d = bus.cmd_wr ? S_AW : S_AR;
            end
         end
         S_AW: begin
            if (bus.aw_ready) state_d = S_W;
         end
         S_W: begin
            if (pop) begin
               cnt_d = cnt_q + 4'd1;
               if (last_beat) state_d = S_B;
            end
         end
         S_B: begin
            if (bus.b_valid) begin
               if (bus.b_resp != 2'b00) err_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_AR: begin
            if (bus.ar_ready) state_d = S_R;
         end
         S_R: begin
            if (rd_hit) begin
               rd_data_d  = bus.r_data;
               rd_valid_d = 1'b1;
               cnt_d      = cnt_q + 4'd1;
               if (bus.r_last) begin
                  state_d = S_IDLE;
                  if (!last_beat) err_d = 1'b1;
               end else if (last_beat) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         run_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         run_q      <= run_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         mem_q      <= mem_d;
      end
   end
endmodule

// File: tb/tb_uart_burst_bridge.sv
// Directed bench for uart_burst_bridge: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_uart_burst_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   uart_burst_bridge_if #(.DATA_W(32), .ADDR_W(28)) bus ();

   uart_burst_bridge #(
      .DATA_W(32), .ADDR_W(28), .FIFO_DEPTH(4), .ID(4'hB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.master)
   );

   function automatic logic [141:0] outs();
      return {bus.cmd_ready, bus.wd_ready, bus.rd_valid,
              bus.rd_data, bus.aw_valid, bus.aw_addr,
              bus.aw_len, bus.w_valid, bus.w_data, bus.w_strb,
              bus.w_last, bus.b_ready, bus.ar_valid,
              bus.ar_addr, bus.ar_len, bus.r_ready, bus.err};
   endfunction

   task automatic idle_inputs();
      bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0;
      bus.cmd_addr = '0; bus.cmd_len = '0;
      bus.wd_data = '0; bus.wd_valid = 1'b0;
      bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
      bus.b_valid = 1'b0; bus.b_resp = 2'b00;
      bus.ar_ready = 1'b0;
      bus.r_data = '0; bus.r_id = '0;
      bus.r_last = 1'b0; bus.r_valid = 1'b0;
   endtask

   task automatic push(input logic [31:0] d);
      bus.wd_valid = 1'b1; bus.wd_data = d;
      @(negedge clk);
      bus.wd_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic wr, input logic [27:0] a,
                           input logic [3:0] l);
      bus.cmd_valid = 1'b1; bus.cmd_wr = wr;
      bus.cmd_addr = a; bus.cmd_len = l;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic pulse_aw();
      bus.aw_ready = 1'b1; @(negedge clk); bus.aw_ready = 1'b0;
   endtask

   task automatic pulse_b(input logic [1:0] r);
      bus.b_valid = 1'b1; bus.b_resp = r;
      @(negedge clk);
      bus.b_valid = 1'b0; bus.b_resp = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      n_checks++;
      if (outs() !== '0) begin
         n_fail++;
         $display("FAIL reset_outs: got %h want 0", outs());
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.cmd_ready, bus.wd_ready, bus.err} !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_release: got %b want 110",
                  {bus.cmd_ready, bus.wd_ready, bus.err});
      end
   endtask

   task automatic test_single_write();
      push(32'hDEADBEEF);
      send_cmd(1'b1, 28'h0000100, 4'd0);
      n_checks++;
      if ({bus.aw_valid, bus.aw_addr, bus.aw_len} !== {1'b1, 28'h100, 4'd0}) begin
         n_fail++;
         $display("FAIL sw_aw: got %b %h %h want 1 100 0",
                  bus.aw_valid, bus.aw_addr, bus.aw_len);
      end
      pulse_aw();
      n_checks++;
      if (bus.w_valid !== 1'b1 || bus.w_data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL sw_wdata: got %b %h want 1 deadbeef",
                  bus.w_valid, bus.w_data);
      end
      n_checks++;
      if (bus.w_last !== 1'b1 || bus.w_strb !== 4'hF) begin
         n_fail++;
         $display("FAIL sw_last_strb: got %b %h want 1 f",
                  bus.w_last, bus.w_strb);
      end
      bus.w_ready = 1'b1; @(negedge clk); bus.w_ready = 1'b0;
      n_checks++;
      if (bus.b_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL sw_bready: got %b want 1", bus.b_ready);
      end
      pulse_b(2'b00);
      n_checks++;
      if ({bus.cmd_ready, bus.err} !== 2'b10) begin
         n_fail++;
         $display("FAIL sw_idle: got %b want 10",
                  {bus.cmd_ready, bus.err});
      end
   endtask

   task automatic test_write_toggle();
      logic [31:0] d [4];
      int   k;
      logic tog;
      d[0] = 32'hA0000001; d[1] = 32'hA0000002;
      d[2] = 32'hA0000003; d[3] = 32'hA0000004;
      for (int i = 0; i < 4; i++) push(d[i]);
      send_cmd(1'b1, 28'h0000200, 4'd3);
      n_checks++;
      if (bus.aw_len !== 4'd3 || bus.aw_addr !== 28'h200) begin
         n_fail++;
         $display("FAIL wt_aw: got %h %h want 200 3",
                  bus.aw_addr, bus.aw_len);
      end
      pulse_aw();
      k = 0;
      tog = 1'b1;
      for (int c = 0; c < 20 && k < 4; c++) begin
         bus.w_ready = tog;
         if (bus.w_valid && tog) begin
            n_checks++;
            if (bus.w_data !== d[k] || bus.w_last !== (k == 3)) begin
               n_fail++;
               $display("FAIL wt_beat%0d: got %h last %b want %h last %b",
                        k, bus.w_data, bus.w_last, d[k], (k == 3));
            end
            k++;
         end
         @(negedge clk);
         tog = !tog;
      end
      bus.w_ready = 1'b0;
      n_checks++;
      if (k != 4 || bus.b_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wt_count: got %0d beats b_ready %b want 4 1",
                  k, bus.b_ready);
      end
      pulse_b(2'b00);
   endtask

   task automatic test_read_filter();
      send_cmd(1'b0, 28'h0000300, 4'd1);
      n_checks++;
      if ({bus.ar_valid, bus.aw_valid, bus.ar_addr, bus.ar_len}
          !== {2'b10, 28'h300, 4'd1}) begin
         n_fail++;
         $display("FAIL rd_ar: got %b%b %h %h want 10 300 1",
                  bus.ar_valid, bus.aw_valid, bus.ar_addr, bus.ar_len);
      end
      bus.ar_ready = 1'b1; @(negedge clk); bus.ar_ready = 1'b0;
      n_checks++;
      if (bus.r_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_rready: got %b want 1", bus.r_ready);
      end
      bus.r_valid = 1'b1; bus.r_id = 4'hB;
      bus.r_data = 32'h11111111; bus.r_last = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h11111111) begin
         n_fail++;
         $display("FAIL rd_beat0: got %b %h want 1 11111111",
                  bus.rd_valid, bus.rd_data);
      end
      bus.r_id = 4'h3; bus.r_data = 32'h33333333;
      @(negedge clk);
      n_checks++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h11111111) begin
         n_fail++;
         $display("FAIL rd_drop: got %b %h want 0 11111111",
                  bus.rd_valid, bus.rd_data);
      end
      bus.r_id = 4'hB; bus.r_data = 32'h22222222; bus.r_last = 1'b1;
      @(negedge clk);
      bus.r_valid = 1'b0; bus.r_last = 1'b0;
      n_checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h22222222) begin
         n_fail++;
         $display("FAIL rd_beat1: got %b %h want 1 22222222",
                  bus.rd_valid, bus.rd_data);
      end
      n_checks++;
      if ({bus.cmd_ready, bus.err} !== 2'b10) begin
         n_fail++;
         $display("FAIL rd_done: got %b want 10",
                  {bus.cmd_ready, bus.err});
      end
      @(negedge clk);
      n_checks++;
      if (bus.rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_pulse: got %b want 0", bus.rd_valid);
      end
   endtask

   task automatic test_err_sticky();
      push(32'hCAFE0001);
      send_cmd(1'b1, 28'h0000400, 4'd0);
      pulse_aw();
      bus.w_ready = 1'b1; @(negedge clk); bus.w_ready = 1'b0;
      pulse_b(2'b10);
      n_checks++;
      if ({bus.err, bus.cmd_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL es_set: got %b want 11",
                  {bus.err, bus.cmd_ready});
      end
      send_cmd(1'b0, 28'h0000480, 4'd0);
      bus.ar_ready = 1'b1; @(negedge clk); bus.ar_ready = 1'b0;
      bus.r_valid = 1'b1; bus.r_id = 4'hB;
      bus.r_data = 32'h55555555; bus.r_last = 1'b1;
      @(negedge clk);
      bus.r_valid = 1'b0; bus.r_last = 1'b0;
      n_checks++;
      if (bus.rd_data !== 32'h55555555 || bus.err !== 1'b1) begin
         n_fail++;
         $display("FAIL es_hold: got %h err %b want 55555555 err 1",
                  bus.rd_data, bus.err);
      end
   endtask

   task automatic test_fifo_full();
      logic [31:0] d [4];
      d[0] = 32'hF0; d[1] = 32'hF1; d[2] = 32'hF2; d[3] = 32'hF3;
      for (int i = 0; i < 4; i++) begin
         bus.wd_valid = 1'b1; bus.wd_data = d[i];
         @(negedge clk);
      end
      bus.wd_valid = 1'b0;
      n_checks++;
      if (bus.wd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ff_full: got %b want 0", bus.wd_ready);
      end
      send_cmd(1'b1, 28'h0000600, 4'd3);
      pulse_aw();
      bus.w_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.wd_valid = (i == 1);
         bus.wd_data = 32'hE5;
         n_checks++;
         if (bus.w_valid !== 1'b1 || bus.w_data !== d[i]) begin
            n_fail++;
            $display("FAIL ff_beat%0d: got %b %h want 1 %h",
                     i, bus.w_valid, bus.w_data, d[i]);
         end
         @(negedge clk);
      end
      bus.w_ready = 1'b0; bus.wd_valid = 1'b0;
      n_checks++;
      if ({bus.wd_ready, bus.b_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL ff_drain: got %b want 11",
                  {bus.wd_ready, bus.b_ready});
      end
      pulse_b(2'b00);
      send_cmd(1'b1, 28'h0000700, 4'd0);
      pulse_aw();
      n_checks++;
      if (bus.w_valid !== 1'b1 || bus.w_data !== 32'hE5) begin
         n_fail++;
         $display("FAIL ff_pushpop: got %b %h want 1 e5",
                  bus.w_valid, bus.w_data);
      end
      bus.w_ready = 1'b1; @(negedge clk); bus.w_ready = 1'b0;
      pulse_b(2'b00);
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
      send_cmd(1'b1, 28'h0000800, 4'd3);
      pulse_aw();
      bus.w_ready = 1'b1;
      repeat (2) @(negedge clk);
      bus.w_ready = 1'b0;
      n_checks++;
      if (bus.w_data !== 32'hB2 || bus.w_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_pre: got %b %h want 1 b2",
                  bus.w_valid, bus.w_data);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (outs() !== '0) begin
         n_fail++;
         $display("FAIL rm_async: got %h want 0", outs());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.cmd_ready, bus.wd_ready, bus.w_valid, bus.err}
          !== 4'b1100) begin
         n_fail++;
         $display("FAIL rm_release: got %b want 1100",
                  {bus.cmd_ready, bus.wd_ready, bus.w_valid, bus.err});
      end
      push(32'h77);
      send_cmd(1'b1, 28'h0000900, 4'd0);
      pulse_aw();
      n_checks++;
      if ({bus.w_valid, bus.w_last} !== 2'b11 || bus.w_data !== 32'h77) begin
         n_fail++;
         $display("FAIL rm_empty: got %b%b %h want 11 77",
                  bus.w_valid, bus.w_last, bus.w_data);
      end
      bus.w_ready = 1'b1; @(negedge clk); bus.w_ready = 1'b0;
      pulse_b(2'b00);
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_write_toggle();
      test_read_filter();
      test_err_sticky();
      test_fifo_full();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
